unit_forward_hazard: RTL and testbench
======================================

Name: unit_forward_hazard

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core.
- Sits beside the ID/EX boundary and keeps its own shift-register history of in-flight destination writes, FWD_DEPTH stages deep.
- Produces a forwarding mux select for each of N_SRC source operands.
- Detects load-use hazards and requests stalls/bubbles.
- Supports debug single-step (pipeline advance enable) and branch flush.

Parameters:
- BITS_REGS, 5, register index width.
- BITS_CORTOCIRCUITO, 3, width of each mux select code. Requirement: FWD_DEPTH <= 2^BITS_CORTOCIRCUITO - 1.
- N_SRC, 2, number of source operands checked (rs, rt, ...).
- FWD_DEPTH, 2, number of post-EX stages able to forward (1..7).
- LOAD_LATENCY, 1, history stages a load must pass before its data is forwardable (0..FWD_DEPTH-1).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_step  in  1  pipeline advance enable; 0 freezes history (debug halt).
- i_flush  in  1  squash the instruction currently entering EX.
- i_issue_valid  in  1  instruction entering EX is real.
- i_issue_rd  in  BITS_REGS  its destination register.
- i_issue_reg_write  in  1  it writes the register file.
- i_issue_mem_read  in  1  it is a load.
- i_src_regs  in  N_SRC*BITS_REGS  source registers of the instruction in ID; source j occupies bits [j*BITS_REGS +: BITS_REGS].
- i_src_used  in  N_SRC  source j is actually read.
- o_mux_sel  out  N_SRC*BITS_CORTOCIRCUITO  forwarding select per source.
- o_stall  out  1  hold PC and IF/ID.
- o_bubble  out  1  insert NOP into ID/EX.

Behaviour:
- History entries h[1..FWD_DEPTH], each holding {valid, rd, reg_write, is_load}. h[1] is EX/MEM, h[2] is MEM/WB, and so on.
- Reset (synchronous, i_reset=1 at posedge): all entries cleared (valid=0). Outputs read 0 in the same cycle because they are combinational on cleared state. Reset overrides i_step and i_flush.
- Advance, on posedge with i_step=1:
  - h[k] <= h[k-1] for k >= 2.
  - h[1] <= issue fields when i_issue_valid=1, i_flush=0 and o_stall=0.
  - Otherwise h[1] <= invalid (bubble).
- Hold: i_step=0 leaves all entries unchanged, regardless of i_flush or issue inputs.
- Match of source j in stage k: h[k].valid && h[k].reg_write && h[k].rd == src_j && src_j != 0 && i_src_used[j].
- Select (combinational): o_mux_sel[j] = k of the lowest (youngest) matching k; 0 if none. The youngest match always wins over older ones.
- Load-use: if the youngest match for any source j has is_load and k <= LOAD_LATENCY, then:
  - o_stall = o_bubble = 1;
  - o_mux_sel[j] = 0 for every such source.
- Stall length: each stalled step advances the load one stage. A load therefore stalls a dependent instruction for exactly LOAD_LATENCY-k+1 steps, with no extra FSM state. Stall deasserts on the step where the load reaches stage LOAD_LATENCY+1.
- i_step=0 during a stall: o_stall stays asserted, history is frozen.
- i_flush together with a stall: the bubble is inserted once (both conditions yield an invalid h[1]).
- Register 0 is never forwarded and never stalls.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds the following output ports:
  - o_stall_cycles  out 32: counts steps (posedges with i_step=1) taken with o_stall=1.
  - o_fwd_events  out 32: counts steps where any o_mux_sel != 0.
- Both counters saturate at 0xFFFFFFFF and are cleared by i_reset.
- When not defined: ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Defaults. Issue rd=3 reg_write; next step, ID src0=3 -> o_mux_sel[0]=1, o_stall=0. One more step -> o_mux_sel[0]=2. One more step -> 0.
- Issue rd=5, then rd=5 again; ID src1=5 -> o_mux_sel[1]=1 (youngest wins over stage 2).
- Issue load rd=7; ID src0=7, src_used=1 -> o_stall=o_bubble=1, sel=0. Next step -> h[1] is a bubble, load is in h[2], stall=0, o_mux_sel[0]=2.
- LOAD_LATENCY=2, FWD_DEPTH=3. Same load sequence -> stall for 2 steps, then o_mux_sel[0]=3.
- Register 0 and unused sources: issue rd=0 reg_write with src0=0 -> sel=0, no stall. src_used[0]=0 with a match -> sel=0.
- i_step=0 for 4 cycles mid-stall -> history and outputs frozen. i_reset during a stall -> next cycle stall=0, all sel=0. With HAZARD_STATS_EN, counters read 0 after reset and 1 after a single stalled step.

Source files
------------

// File: rtl/unit_forward_hazard.sv
// unit_forward_hazard: operand forwarding select and load-use stall unit; optional counters under HAZARD_STATS_EN
module unit_forward_hazard #(
   parameter int BITS_REGS          = 5,
   parameter int BITS_CORTOCIRCUITO = 3,
   parameter int N_SRC              = 2,
   parameter int FWD_DEPTH          = 2,
   parameter int LOAD_LATENCY       = 1
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_step,
   input  logic                                i_flush,
   input  logic                                i_issue_valid,
   input  logic [BITS_REGS-1:0]                i_issue_rd,
   input  logic                                i_issue_reg_write,
   input  logic                                i_issue_mem_read,
   input  logic [N_SRC*BITS_REGS-1:0]          i_src_regs,
   input  logic [N_SRC-1:0]                    i_src_used,
   output logic [N_SRC*BITS_CORTOCIRCUITO-1:0] o_mux_sel,
   output logic                                o_stall,
   output logic                                o_bubble
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]                         o_stall_cycles,
   output logic [31:0]                         o_fwd_events
`endif
);
   logic [FWD_DEPTH:1]          h_valid, h_wr, h_load;
   logic [BITS_REGS-1:0]        h_rd [1:FWD_DEPTH];
   logic [BITS_CORTOCIRCUITO-1:0] sel [N_SRC];
   logic [N_SRC-1:0]            lu;
   logic                        take;

   assign take     = i_issue_valid && !i_flush && !o_stall;
   assign o_stall  = |lu;
   assign o_bubble = o_stall;

   // youngest matching stage per source; a too-young load blanks the select and stalls
   always_comb begin
      o_mux_sel = '0;
      for (int j = 0; j < N_SRC; j++) begin
         sel[j] = '0;
         lu[j]  = 1'b0;
         for (int k = FWD_DEPTH; k >= 1; k--)
            if (h_valid[k] && h_wr[k] && i_src_used[j] &&
                h_rd[k] == i_src_regs[j*BITS_REGS +: BITS_REGS] &&
                i_src_regs[j*BITS_REGS +: BITS_REGS] != '0) begin
               sel[j] = BITS_CORTOCIRCUITO'(k);
               lu[j]  = h_load[k] && (k <= LOAD_LATENCY);
            end
         o_mux_sel[j*BITS_CORTOCIRCUITO +: BITS_CORTOCIRCUITO] = lu[j] ? '0 : sel[j];
      end
   end

   // destination history shifts one stage per step; stall or flush enters a bubble
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         h_valid <= '0;
         h_wr    <= '0;
         h_load  <= '0;
         for (int k = 1; k <= FWD_DEPTH; k++) h_rd[k] <= '0;
      end else if (i_step) begin
         for (int k = 2; k <= FWD_DEPTH; k++) begin
            h_valid[k] <= h_valid[k-1];
            h_wr[k]    <= h_wr[k-1];
            h_load[k]  <= h_load[k-1];
            h_rd[k]    <= h_rd[k-1];
         end
         h_valid[1] <= take;
         h_wr[1]    <= take && i_issue_reg_write;
         h_load[1]  <= take && i_issue_mem_read;
         h_rd[1]    <= take ? i_issue_rd : '0;
      end
   end

`ifdef HAZARD_STATS_EN
   // saturating counts of stalled steps and steps with any forwarding active
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_stall_cycles <= '0;
         o_fwd_events   <= '0;
      end else if (i_step) begin
         if (o_stall && o_stall_cycles != '1) o_stall_cycles <= o_stall_cycles + 32'd1;
         if (|o_mux_sel && o_fwd_events != '1) o_fwd_events <= o_fwd_events + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_unit_forward_hazard.sv
// tb_unit_forward_hazard: scoreboard bench for two configurations (depth2/latency1 and depth3/latency2)
module tb_unit_forward_hazard;
   typedef struct packed { bit v; bit [4:0] rd; bit wr; bit ld; } ent_t;
   typedef struct packed { bit [5:0] sel_a; bit st_a; bit [5:0] sel_b; bit st_b; int sc; int fe; } exp_t;

   logic clk = 0;
   logic rst = 1, stp = 0, fl = 0, iv = 0, iwr = 0, ild = 0;
   logic [4:0] ird = 0;
   logic [9:0] srcs = 0;
   logic [1:0] used = 0;
   logic [5:0] sel_a, sel_b;
   logic st_a, bub_a, st_b, bub_b;
   logic [31:0] sc_a, fe_a, sc_b, fe_b;

   ent_t qa[$], qb[$];
   exp_t sb[$];
   bit [5:0] cur_sel_a = 0, cur_sel_b = 0;
   bit cur_st_a = 0, cur_st_b = 0;
   int m_sc = 0, m_fe = 0;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   unit_forward_hazard dut_a (
      .i_clk(clk), .i_reset(rst), .i_step(stp), .i_flush(fl), .i_issue_valid(iv),
      .i_issue_rd(ird), .i_issue_reg_write(iwr), .i_issue_mem_read(ild),
      .i_src_regs(srcs), .i_src_used(used), .o_mux_sel(sel_a), .o_stall(st_a), .o_bubble(bub_a)
`ifdef HAZARD_STATS_EN
      , .o_stall_cycles(sc_a), .o_fwd_events(fe_a)
`endif
   );

   unit_forward_hazard #(.FWD_DEPTH(3), .LOAD_LATENCY(2)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_step(stp), .i_flush(fl), .i_issue_valid(iv),
      .i_issue_rd(ird), .i_issue_reg_write(iwr), .i_issue_mem_read(ild),
      .i_src_regs(srcs), .i_src_used(used), .o_mux_sel(sel_b), .o_stall(st_b), .o_bubble(bub_b)
`ifdef HAZARD_STATS_EN
      , .o_stall_cycles(sc_b), .o_fwd_events(fe_b)
`endif
   );

   // queue index i holds pipeline stage i+1; the first match from the front is the youngest
   function automatic void eval(input ent_t q[$], input int ll, input bit [9:0] s,
                                input bit [1:0] u, output bit [5:0] sel, output bit st);
      bit [4:0] r;
      int idx;
      sel = 0;
      st = 0;
      for (int j = 0; j < 2; j++) begin
         r = s[j*5 +: 5];
         idx = -1;
         for (int i = 0; i < q.size(); i++)
            if (idx < 0 && q[i].v && q[i].wr && q[i].rd == r && r != 0 && u[j]) idx = i;
         if (idx >= 0) begin
            if (q[idx].ld && idx + 1 <= ll) st = 1;
            else sel[j*3 +: 3] = 3'(idx + 1);
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: retire the held inputs into the model, then apply new inputs and queue the expectation
   task automatic cyc(input bit r, input bit p, input bit f, input bit v, input bit [4:0] d,
                      input bit w, input bit l, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] u);
      ent_t e, bub;
      exp_t x;
      @(posedge clk);
      #1;
      bub = '0;
      e = '{v: 1'b1, rd: ird, wr: iwr, ld: ild};
      if (rst) begin
         qa.delete();
         qb.delete();
         m_sc = 0;
         m_fe = 0;
      end else if (stp) begin
         if (cur_st_a) m_sc++;
         if (cur_sel_a != 0) m_fe++;
         qa.push_front((iv && !fl && !cur_st_a) ? e : bub);
         qb.push_front((iv && !fl && !cur_st_b) ? e : bub);
         if (qa.size() > 2) void'(qa.pop_back());
         if (qb.size() > 3) void'(qb.pop_back());
      end
      rst = r; stp = p; fl = f; iv = v; ird = d; iwr = w; ild = l; srcs = {s1, s0}; used = u;
      eval(qa, 1, srcs, used, cur_sel_a, cur_st_a);
      eval(qb, 2, srcs, used, cur_sel_b, cur_st_b);
      x.sel_a = cur_sel_a; x.st_a = cur_st_a; x.sel_b = cur_sel_b; x.st_b = cur_st_b;
      x.sc = m_sc; x.fe = m_fe;
      sb.push_back(x);
   endtask

   // monitor: outputs are combinational, so one expectation is consumed each cycle
   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("sel_a", int'(sel_a), int'(x.sel_a));
         chk("stall_a", int'(st_a), int'(x.st_a));
         chk("bubble_a", int'(bub_a), int'(x.st_a));
         chk("sel_b", int'(sel_b), int'(x.sel_b));
         chk("stall_b", int'(st_b), int'(x.st_b));
         chk("bubble_b", int'(bub_b), int'(x.st_b));
`ifdef HAZARD_STATS_EN
         chk("stall_cycles", int'(sc_a), x.sc);
         chk("fwd_events", int'(fe_a), x.fe);
`endif
      end
   end

   initial begin
      sc_a = 0; fe_a = 0; sc_b = 0; fe_b = 0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 3, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
      cyc(0, 1, 0, 1, 5, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 5, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 5, 2);
      cyc(0, 1, 0, 1, 7, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 9, 1, 0, 7, 0, 1);
      cyc(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 1, 4, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 4, 0, 0);
      cyc(0, 1, 0, 1, 6, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 9, 1, 0, 6, 0, 1);
      cyc(0, 1, 1, 1, 9, 1, 0, 6, 0, 1);
      cyc(0, 1, 0, 1, 9, 1, 0, 6, 0, 1);
      cyc(0, 1, 0, 1, 6, 1, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 9, 1, 0, 6, 6, 3);
      cyc(1, 1, 0, 1, 9, 1, 0, 6, 6, 3);
      cyc(0, 1, 0, 1, 9, 1, 0, 6, 6, 3);
      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 80, 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 35, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)));
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
